// File: rtl/mersenne_pkg.sv
// rtl/mersenne_pkg.sv - shared state encoding and candidate residue filter
package mersenne_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILTER = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } state_e;

  // Any prime factor of 2^p-1 is congruent to +1 or -1 mod 8.
  localparam logic [2:0] RESIDUE_POS = 3'd1;
  localparam logic [2:0] RESIDUE_NEG = 3'd7;

  function automatic logic is_candidate(input logic [2:0] d_lo);
    return (d_lo == RESIDUE_POS) || (d_lo == RESIDUE_NEG);
  endfunction

endpackage

// File: rtl/mersenne_candidate_sequencer.sv
// rtl/mersenne_candidate_sequencer.sv - walks d = 2kp+1 and issues survivors to the trial-division core
module mersenne_candidate_sequencer
  import mersenne_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int KWIDTH = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              search_start,
  input  logic [WIDTH-1:0]  p_in,
  input  logic [KWIDTH-1:0] k_max_in,
  output logic              busy,
  output logic              cand_start,
  output logic [WIDTH-1:0]  cand_p,
  output logic [WIDTH-1:0]  cand_d,
  input  logic              cand_divides,
  input  logic              cand_finished,
  output logic              done,
  output logic              found,
  output logic              overflow,
  output logic [WIDTH-1:0]  factor,
  output logic [KWIDTH-1:0] k_found,
  output logic [KWIDTH-1:0] tested
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_FILTER = FILTER;
  localparam logic [2:0] S_ISSUE  = ISSUE;
  localparam logic [2:0] S_WAIT   = WAIT;
  localparam logic [2:0] S_FINISH = FINISH;

  logic [2:0]        state;
  logic [KWIDTH-1:0] k_max_q;
  logic [KWIDTH-1:0] k_q;
  // Two guard bits above WIDTH so that d + 2p can never wrap before overflow is seen.
  logic [WIDTH+1:0]  d_q;
  logic [WIDTH+1:0]  two_p;
  logic              d_ovf;

  assign two_p      = {1'b0, cand_p, 1'b0};
  assign d_ovf      = |d_q[WIDTH+1:WIDTH];
  assign cand_start = (state == S_ISSUE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      cand_p   <= '0;
      k_max_q  <= '0;
      k_q      <= '0;
      d_q      <= '0;
      cand_d   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      overflow <= 1'b0;
      factor   <= '0;
      k_found  <= '0;
      tested   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (search_start) begin
            cand_p   <= p_in;
            k_max_q  <= k_max_in;
            d_q      <= {1'b0, p_in, 1'b1};
            k_q      <= KWIDTH'(1);
            busy     <= 1'b1;
            done     <= 1'b0;
            found    <= 1'b0;
            overflow <= 1'b0;
            factor   <= '0;
            k_found  <= '0;
            tested   <= '0;
            if ((p_in[WIDTH-1:1] == '0) || (k_max_in == '0))
              state <= S_FINISH;
            else
              state <= S_FILTER;
          end
        end

        S_FILTER: begin
          if (d_ovf) begin
            overflow <= 1'b1;
            state    <= S_FINISH;
          end else if (k_q > k_max_q) begin
            state <= S_FINISH;
          end else if (is_candidate(d_q[2:0])) begin
            cand_d <= d_q[WIDTH-1:0];
            state  <= S_ISSUE;
          end else begin
            d_q <= d_q + two_p;
            k_q <= k_q + KWIDTH'(1);
          end
        end

        // A finished strobe coincident with the start pulse belongs to no issued candidate.
        S_ISSUE: state <= S_WAIT;

        S_WAIT: begin
          if (cand_finished) begin
            tested <= tested + KWIDTH'(1);
            if (cand_divides) begin
              found   <= 1'b1;
              factor  <= d_q[WIDTH-1:0];
              k_found <= k_q;
              state   <= S_FINISH;
            end else begin
              d_q   <= d_q + two_p;
              k_q   <= k_q + KWIDTH'(1);
              state <= S_FILTER;
            end
          end
        end

        S_FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mersenne_candidate_sequencer.sv
// tb/tb_mersenne_candidate_sequencer.sv - randomized self-checking bench with arithmetic reference model
module tb_mersenne_candidate_sequencer;

  localparam int WIDTH  = 32;
  localparam int KWIDTH = 32;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              search_start = 1'b0;
  logic [WIDTH-1:0]  p_in = '0;
  logic [KWIDTH-1:0] k_max_in = '0;
  logic              busy, cand_start, done, found, overflow;
  logic [WIDTH-1:0]  cand_p, cand_d, factor;
  logic [KWIDTH-1:0] k_found, tested;
  logic              cand_divides = 1'b0;
  logic              cand_finished = 1'b0;

  mersenne_candidate_sequencer #(.WIDTH(WIDTH), .KWIDTH(KWIDTH)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .search_start(search_start),
    .p_in(p_in), .k_max_in(k_max_in), .busy(busy), .cand_start(cand_start),
    .cand_p(cand_p), .cand_d(cand_d), .cand_divides(cand_divides),
    .cand_finished(cand_finished), .done(done), .found(found),
    .overflow(overflow), .factor(factor), .k_found(k_found), .tested(tested)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // True divisibility of 2^p-1 by d via modular exponentiation.
  function automatic bit divides(input logic [31:0] p, input longint unsigned d);
    longint unsigned r;
    r = 1;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % d;
      if (p[i]) r = (r * 2) % d;
    end
    return r == 1;
  endfunction

  // Reference model: expected issue list and results from the search rules.
  logic [WIDTH-1:0]  exp_p, exp_factor;
  logic [KWIDTH-1:0] exp_k, exp_tested;
  bit                exp_found, exp_ovf, exp_trivial, first_k1;
  logic [WIDTH-1:0]  exp_q[$];

  task automatic run_model(input logic [31:0] p, input logic [31:0] kmax);
    longint unsigned d;
    exp_q.delete();
    exp_found = 0; exp_ovf = 0; exp_factor = '0; exp_k = '0; exp_tested = '0;
    exp_trivial = (p < 2) || (kmax == 0);
    first_k1 = 0;
    if (!exp_trivial) begin
      for (longint unsigned k = 1; ; k++) begin
        d = 2 * k * longint'(p) + 1;
        if (d >= 64'h1_0000_0000) begin exp_ovf = 1; break; end
        if (k > kmax) break;
        if (d % 8 == 1 || d % 8 == 7) begin
          if (k == 1) first_k1 = 1;
          exp_q.push_back(d[31:0]);
          exp_tested++;
          if (divides(p, d)) begin
            exp_found = 1; exp_factor = d[31:0]; exp_k = k[31:0];
            break;
          end
        end
      end
    end
  endtask

  // Core model: answers each start after a random delay, sometimes with a junk strobe in the issue cycle.
  bit core_manual = 0;
  int fin_cyc = -100;
  initial begin
    logic [WIDTH-1:0] d_seen;
    int dly;
    forever begin
      @(negedge sys_clk);
      if (cand_start && !core_manual) begin
        d_seen = cand_d;
        cand_finished = ($urandom_range(0, 3) == 0);
        cand_divides  = cand_finished;
        dly = $urandom_range(0, 3);
        @(negedge sys_clk);
        cand_finished = 1'b0; cand_divides = 1'b0;
        repeat (dly) @(negedge sys_clk);
        check("cand_d_stable", cand_d, d_seen);
        cand_finished = 1'b1;
        cand_divides  = divides(cand_p, longint'(d_seen));
        fin_cyc = cyc;
        @(negedge sys_clk);
        cand_finished = 1'b0; cand_divides = 1'b0;
      end
    end
  end

  // Compare process: issued candidates and held results, every cycle.
  bit armed = 0;
  bit prev_done = 0;
  int acc_cyc = 0;
  int n_starts = 0;
  always @(negedge sys_clk) begin
    if (armed) begin
      if (cand_start) begin
        n_starts++;
        if (exp_q.size() == 0) check("unexpected_cand_start", cand_start, 0);
        else begin
          check("cand_d", cand_d, exp_q.pop_front());
          check("cand_p", cand_p, exp_p);
        end
        if (n_starts == 1 && first_k1) check("first_start_latency", cyc - acc_cyc, 2);
      end
      if (done) begin
        check("found", found, exp_found);
        check("overflow", overflow, exp_ovf);
        check("factor", factor, exp_factor);
        check("k_found", k_found, exp_k);
        check("tested", tested, exp_tested);
        check("busy_when_done", busy, 0);
        check("start_count", n_starts, exp_tested);
        if (!prev_done && exp_found) check("done_after_finished", cyc - fin_cyc, 2);
        if (!prev_done && exp_trivial) check("trivial_done_latency", cyc - acc_cyc, 2);
      end
    end
    prev_done = done;
  end

  task automatic run_search(input logic [31:0] p, input logic [31:0] kmax, input bit poke);
    int t;
    armed = 0;
    @(negedge sys_clk);
    p_in = p; k_max_in = kmax; search_start = 1'b1;
    run_model(p, kmax);
    exp_p = p; n_starts = 0; acc_cyc = cyc;
    @(negedge sys_clk);
    search_start = 1'b0; p_in = $urandom; k_max_in = $urandom;
    armed = 1;
    check("busy_after_accept", busy, 1);
    if (poke && exp_q.size() > 0) begin
      t = 0;
      while (!cand_start && t < 200) begin @(negedge sys_clk); t++; end
      if (cand_start) begin
        @(negedge sys_clk);
        search_start = 1'b1; p_in = p + 32'd6; k_max_in = kmax + 32'd3;
        @(negedge sys_clk);
        search_start = 1'b0;
        check("poke_cand_p", cand_p, p);
      end
    end
    t = 0;
    while (!done && t < 3000) begin @(negedge sys_clk); t++; end
    check("done_reached", done, 1);
    @(negedge sys_clk);
    check("all_issued", exp_q.size(), 0);
    repeat ($urandom_range(0, 3)) @(negedge sys_clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int t;
    logic [31:0] rp, rk;
    repeat (3) @(negedge sys_clk);
    check("reset_flags", {busy, done, found, overflow, cand_start}, 0);
    check("reset_factor_kfound", {factor, k_found}, 0);
    check("reset_tested_cand_d", {tested, cand_d}, 0);
    sys_rst = 1'b0;

    run_model(29, 10);
    check("model_p29_factor", exp_factor, 233);
    check("model_p29_k", exp_k, 4);

    run_search(11, 10, 0);
    check("p11_found", found, 1); check("p11_factor", factor, 23);
    check("p11_k", k_found, 1);   check("p11_tested", tested, 1);

    run_search(29, 10, 0);
    check("p29_factor", factor, 233); check("p29_k", k_found, 4);
    check("p29_tested", tested, 2);   check("p29_starts", n_starts, 2);

    run_search(13, 5, 0);
    check("p13_found", found, 0); check("p13_factor", factor, 0);
    check("p13_tested", tested, 2); check("p13_ovf", overflow, 0);

    run_search(32'h7FFF_FFFF, 4, 0);
    check("big_found", found, 0); check("big_ovf", overflow, 1);
    check("big_tested", tested, 1);

    run_search(1, 5, 0);
    check("p1_found", found, 0); check("p1_tested", tested, 0);
    check("p1_starts", n_starts, 0);

    run_search(11, 10, 1);
    check("poke_factor", factor, 23); check("poke_cand_p_hold", cand_p, 11);

    // Reset while waiting on the core, then a late finished strobe.
    armed = 0; core_manual = 1;
    @(negedge sys_clk); p_in = 11; k_max_in = 10; search_start = 1'b1;
    @(negedge sys_clk); search_start = 1'b0;
    t = 0;
    while (!cand_start && t < 50) begin @(negedge sys_clk); t++; end
    check("rst_issue_seen", cand_start, 1);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("midrst_flags", {busy, done, found, overflow, cand_start}, 0);
    check("midrst_factor_kfound", {factor, k_found}, 0);
    check("midrst_tested_cand_d", {tested, cand_d}, 0);
    check("midrst_cand_p", cand_p, 0);
    cand_finished = 1'b1; cand_divides = 1'b1;
    @(negedge sys_clk);
    cand_finished = 1'b0; cand_divides = 1'b0;
    seen = 0;
    repeat (6) begin seen |= cand_start | done | busy | found; @(negedge sys_clk); end
    check("late_finish_ignored", seen, 0);
    core_manual = 0;

    run_search(23, 5, 0);
    check("p23_factor", factor, 47); check("p23_k", k_found, 1);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0, 1: begin rp = $urandom_range(2, 300); rk = $urandom_range(1, 40); end
        2:    begin rp = $urandom_range(32'h0400_0000, 32'hFFFF_FFFF); rk = $urandom_range(1, 200); end
        3:    begin rp = $urandom_range(0, 1); rk = $urandom; end
        default: begin rp = $urandom_range(2, 60); rk = $urandom_range(0, 3); end
      endcase
      run_search(rp, rk, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
